// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the RV32 multi-cycle control path: opcode constants,
// ALU operation codes and the sequencer state type.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_TYPE_R = 7'b0110011;
  localparam logic [6:0] OP_TYPE_L = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S = 7'b0100011;

  // ALU codes follow {funct7[5], funct3} so R-type ops map straight through.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    TRAP
  } mc_state_e;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_TYPE_L) || (opcode == OP_TYPE_S);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational opcode/funct decode to ALU operation and operand-B select.
// Also used by the single-cycle control path.
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_control,
  output logic       o_alu_src_sel
);

  always_comb begin
    // NOTE: every output gets a default before the branches so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    o_alu_control = ALU_ADD;
    o_alu_src_sel = 1'b0;
    if (i_opcode == OP_TYPE_R) begin
      o_alu_control = {i_funct7b5, i_funct3};
    end else if (is_mem_op(i_opcode)) begin
      o_alu_control = ALU_ADD;
      o_alu_src_sel = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for R-type, load and store.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP instead of retiring as NOPs.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             instrReady,
  input  logic             dataReady,
  output logic             irWe,
  output logic             pcEn,
  output logic             regFileWe,
  output logic [3:0]       aluControl,
  output logic             aluSrcMuxSel,
  output logic             dataReq,
  output logic             dataWe,
  output logic             wdataSel,
  output logic [CNT_W-1:0] retireCnt,
  output logic             illegalInstr
);

  mc_state_e        r_state;
  mc_state_e        w_next_state;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [6:0]       w_opcode;
  logic             w_is_r;
  logic             w_is_l;
  logic             w_is_s;
  logic [3:0]       w_dec_alu;
  logic             w_dec_src;
  logic             w_unused;

  assign w_opcode = instrCode[6:0];
  assign w_is_r   = (w_opcode == OP_TYPE_R);
  assign w_is_l   = (w_opcode == OP_TYPE_L);
  assign w_is_s   = (w_opcode == OP_TYPE_S);
  assign w_unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  multicycle_control_unit_alu_decoder u_alu_decoder (
    .i_opcode      (w_opcode),
    .i_funct3      (instrCode[14:12]),
    .i_funct7b5    (instrCode[30]),
    .o_alu_control (w_dec_alu),
    .o_alu_src_sel (w_dec_src)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are forced low while reset is high so an in-flight access drops at once.
  always_comb begin
    w_next_state = r_state;
    irWe         = 1'b0;
    pcEn         = 1'b0;
    regFileWe    = 1'b0;
    aluControl   = ALU_ADD;
    aluSrcMuxSel = 1'b0;
    dataReq      = 1'b0;
    dataWe       = 1'b0;
    wdataSel     = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          if (instrReady) begin
            irWe         = 1'b1;
            w_next_state = DECODE;
          end
        end
        DECODE: begin
          if (w_is_r || w_is_l || w_is_s) begin
            w_next_state = EXECUTE;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            w_next_state = TRAP;
`else
            pcEn         = 1'b1;
            w_next_state = FETCH;
`endif
          end
        end
        EXECUTE: begin
          aluControl   = w_dec_alu;
          aluSrcMuxSel = w_dec_src;
          w_next_state = w_is_r ? WB : MEM;
        end
        MEM: begin
          aluControl   = w_dec_alu;
          aluSrcMuxSel = w_dec_src;
          dataReq      = 1'b1;
          dataWe       = w_is_s;
          if (dataReady) begin
            if (w_is_s) begin
              pcEn         = 1'b1;
              w_next_state = FETCH;
            end else begin
              w_next_state = WB;
            end
          end
        end
        WB: begin
          aluControl   = w_dec_alu;
          aluSrcMuxSel = w_dec_src;
          regFileWe    = 1'b1;
          pcEn         = 1'b1;
          wdataSel     = w_is_l;
          w_next_state = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          w_next_state = TRAP;
        end
`endif
        default: begin
          w_next_state = FETCH;
        end
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // TRAP has no exit other than reset, so the state itself is the sticky flag.
  assign illegalInstr = (r_state == TRAP);
`else
  assign illegalInstr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (pcEn) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign retireCnt = r_retire_cnt;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the stimulus script queues the
// expected outputs of every cycle and a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

  localparam logic [31:0] I_SUB = 32'h40B50533;
  localparam logic [31:0] I_SLL = 32'h00B51533;
  localparam logic [31:0] I_LD  = 32'h0040A283;
  localparam logic [31:0] I_ST  = 32'h0050A423;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        instrReady;
  logic        dataReady;
  logic        irWe;
  logic        pcEn;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic        dataReq;
  logic        dataWe;
  logic        wdataSel;
  logic [31:0] retireCnt;
  logic        illegalInstr;

  multicycle_control_unit #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .instrCode    (instrCode),
    .instrReady   (instrReady),
    .dataReady    (dataReady),
    .irWe         (irWe),
    .pcEn         (pcEn),
    .regFileWe    (regFileWe),
    .aluControl   (aluControl),
    .aluSrcMuxSel (aluSrcMuxSel),
    .dataReq      (dataReq),
    .dataWe       (dataWe),
    .wdataSel     (wdataSel),
    .retireCnt    (retireCnt),
    .illegalInstr (illegalInstr)
  );

  always #5 clk = ~clk;

  // Flag vector order: {irWe, pcEn, regFileWe, aluSrcMuxSel, dataReq, dataWe, wdataSel, illegalInstr}
  typedef struct {
    string       name;
    logic [7:0]  flags;
    logic [3:0]  alu;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;

  // Drive one cycle of inputs just after the rising edge and queue what the DUT must show.
  task automatic cyc(input string name, input logic rst_v, input logic ir, input logic dr,
                     input logic [31:0] instr, input logic [7:0] flags, input logic [3:0] alu);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst_v;
    instrReady = ir;
    dataReady  = dr;
    instrCode  = instr;
    if (rst_v) exp_cnt = 0;
    e.name  = name;
    e.flags = flags;
    e.alu   = alu;
    e.cnt   = exp_cnt;
    sb_q.push_back(e);
    if (flags[6]) exp_cnt = exp_cnt + 1;
  endtask

  task automatic check(input string name, input logic [7:0] got_f, input logic [3:0] got_a,
                       input logic [31:0] got_c, input exp_t e);
    checks++;
    if (got_f !== e.flags || got_a !== e.alu || got_c !== e.cnt) begin
      errors++;
      $display("FAIL %s: got flags=%b alu=%b cnt=%0d, expected flags=%b alu=%b cnt=%0d",
               name, got_f, got_a, got_c, e.flags, e.alu, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name,
            {irWe, pcEn, regFileWe, aluSrcMuxSel, dataReq, dataWe, wdataSel, illegalInstr},
            aluControl, retireCnt, e);
    end
  end

  initial begin
    reset      = 1'b1;
    instrReady = 1'b0;
    dataReady  = 1'b0;
    instrCode  = 32'h0;

    cyc("reset_hold",       1, 0, 0, I_SUB, 8'b0000_0000, 4'b0000);
    cyc("reset_hold_ready", 1, 1, 1, I_SUB, 8'b0000_0000, 4'b0000);
    cyc("fetch_idle",       0, 0, 0, I_SUB, 8'b0000_0000, 4'b0000);

    // R-type SUB, 4 cycles
    cyc("sub_fetch",   0, 1, 0, I_SUB, 8'b1000_0000, 4'b0000);
    cyc("sub_decode",  0, 0, 0, I_SUB, 8'b0000_0000, 4'b0000);
    cyc("sub_execute", 0, 0, 0, I_SUB, 8'b0000_0000, 4'b1000);
    cyc("sub_wb",      0, 0, 0, I_SUB, 8'b0110_0000, 4'b1000);

    // Load with dataReady two cycles late, 7 cycles
    cyc("ld_fetch",   0, 1, 0, I_LD, 8'b1000_0000, 4'b0000);
    cyc("ld_decode",  0, 0, 0, I_LD, 8'b0000_0000, 4'b0000);
    cyc("ld_execute", 0, 0, 0, I_LD, 8'b0001_0000, 4'b0000);
    cyc("ld_mem_w1",  0, 0, 0, I_LD, 8'b0001_1000, 4'b0000);
    cyc("ld_mem_w2",  0, 0, 0, I_LD, 8'b0001_1000, 4'b0000);
    cyc("ld_mem_rdy", 0, 0, 1, I_LD, 8'b0001_1000, 4'b0000);
    cyc("ld_wb",      0, 0, 0, I_LD, 8'b0111_0010, 4'b0000);

    // Store, zero wait, 4 cycles
    cyc("st_fetch",   0, 1, 0, I_ST, 8'b1000_0000, 4'b0000);
    cyc("st_decode",  0, 0, 0, I_ST, 8'b0000_0000, 4'b0000);
    cyc("st_execute", 0, 0, 0, I_ST, 8'b0001_0000, 4'b0000);
    cyc("st_mem",     0, 0, 1, I_ST, 8'b0101_1100, 4'b0000);

    // Unknown opcode
    cyc("ill_fetch", 0, 1, 0, I_ILL, 8'b1000_0000, 4'b0000);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_decode", 0, 0, 0, I_ILL, 8'b0000_0000, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      cyc("ill_trap", 0, 1, 1, I_ILL, 8'b0000_0001, 4'b0000);
    end
    cyc("trap_reset", 1, 0, 0, I_ILL, 8'b0000_0000, 4'b0000);
    cyc("trap_fetch", 0, 0, 0, I_ILL, 8'b0000_0000, 4'b0000);
`else
    cyc("ill_decode", 0, 0, 0, I_ILL, 8'b0100_0000, 4'b0000);
`endif

    // instrReady low for three FETCH cycles, then SLL with stray readies ignored
    cyc("stall_1",      0, 0, 1, I_SLL, 8'b0000_0000, 4'b0000);
    cyc("stall_2",      0, 0, 0, I_SLL, 8'b0000_0000, 4'b0000);
    cyc("stall_3",      0, 0, 1, I_SLL, 8'b0000_0000, 4'b0000);
    cyc("sll_fetch",    0, 1, 0, I_SLL, 8'b1000_0000, 4'b0000);
    cyc("sll_decode",   0, 1, 1, I_SLL, 8'b0000_0000, 4'b0000);
    cyc("sll_execute",  0, 1, 1, I_SLL, 8'b0000_0000, 4'b0001);
    cyc("sll_wb",       0, 0, 1, I_SLL, 8'b0110_0000, 4'b0001);

    // Reset asserted mid-MEM of a stalled load
    cyc("rl_fetch",     0, 1, 0, I_LD, 8'b1000_0000, 4'b0000);
    cyc("rl_decode",    0, 0, 0, I_LD, 8'b0000_0000, 4'b0000);
    cyc("rl_execute",   0, 0, 0, I_LD, 8'b0001_0000, 4'b0000);
    cyc("rl_mem",       0, 0, 0, I_LD, 8'b0001_1000, 4'b0000);
    cyc("rl_reset",     1, 0, 0, I_LD, 8'b0000_0000, 4'b0000);
    cyc("rl_reset_rdy", 1, 1, 1, I_LD, 8'b0000_0000, 4'b0000);
    cyc("rl_post",      0, 0, 0, I_LD, 8'b0000_0000, 4'b0000);

    // Normal operation resumes from FETCH
    cyc("sub2_fetch",   0, 1, 0, I_SUB, 8'b1000_0000, 4'b0000);
    cyc("sub2_decode",  0, 0, 0, I_SUB, 8'b0000_0000, 4'b0000);
    cyc("sub2_execute", 0, 0, 0, I_SUB, 8'b0000_0000, 4'b1000);
    cyc("sub2_wb",      0, 0, 0, I_SUB, 8'b0110_0000, 4'b1000);
    cyc("final_idle",   0, 0, 0, I_SUB, 8'b0000_0000, 4'b0000);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
